// File: rtl/axi_arbiter.sv
// 2:1 AXI-Lite arbiter: grants whole transactions to one of two masters, one outstanding downstream.
// Define AXI_ARBITER_FIXED_PRIO_EN for fixed priority (master 0 wins); default is round-robin.
module axi_arbiter #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
) (
    input  logic                        axi_clk,
    input  logic                        axi_resetn,

    // Upstream: two masters, master m in bit m / slice [m*W +: W]
    input  logic [2*AXI_ADDR_WIDTH-1:0] in_axi_awaddr,
    input  logic [1:0]                  in_axi_awvalid,
    output logic [1:0]                  in_axi_awready,
    input  logic [2*AXI_DATA_WIDTH-1:0] in_axi_wdata,
    input  logic [1:0]                  in_axi_wstrb,
    input  logic [1:0]                  in_axi_wvalid,
    output logic [1:0]                  in_axi_wready,
    output logic [1:0]                  in_axi_bresp,
    output logic [1:0]                  in_axi_bvalid,
    input  logic [1:0]                  in_axi_bready,
    input  logic [2*AXI_ADDR_WIDTH-1:0] in_axi_araddr,
    input  logic [1:0]                  in_axi_arvalid,
    output logic [1:0]                  in_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   in_axi_rdata,
    output logic [1:0]                  in_axi_rresp,
    output logic [1:0]                  in_axi_rvalid,
    input  logic [1:0]                  in_axi_rready,

    // Downstream: single shared slave
    output logic [AXI_ADDR_WIDTH-1:0]   out_axi_awaddr,
    output logic                        out_axi_awvalid,
    input  logic                        out_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   out_axi_wdata,
    output logic                        out_axi_wstrb,
    output logic                        out_axi_wvalid,
    input  logic                        out_axi_wready,
    input  logic [1:0]                  out_axi_bresp,
    input  logic                        out_axi_bvalid,
    output logic                        out_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   out_axi_araddr,
    output logic                        out_axi_arvalid,
    input  logic                        out_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   out_axi_rdata,
    input  logic [1:0]                  out_axi_rresp,
    input  logic                        out_axi_rvalid,
    output logic                        out_axi_rready
);

    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            grant_q, grant_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wstrb_q, wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;

    logic [1:0]      wreq;
    logic [1:0]      rreq;
    logic [1:0]      req;
    logic            sel;

    // A write needs AW and W together; a lone AW or W is ignored.
    always_comb begin
        wreq = in_axi_awvalid & in_axi_wvalid;
        rreq = in_axi_arvalid;
        req  = wreq | rreq;
`ifdef AXI_ARBITER_FIXED_PRIO_EN
        sel  = ~req[0];
`else
        sel  = req[~last_grant_q] ? ~last_grant_q : last_grant_q;
`endif
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        awaddr_d       = awaddr_q;
        araddr_d       = araddr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        arvalid_d      = arvalid_q;
        in_axi_awready = 2'b00;
        in_axi_wready  = 2'b00;
        in_axi_arready = 2'b00;
        in_axi_bvalid  = 2'b00;
        in_axi_rvalid  = 2'b00;
        out_axi_bready = 1'b0;
        out_axi_rready = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Accepts are gated by reset so nothing handshakes while reset is held.
                if (axi_resetn && (req != 2'b00)) begin
                    grant_d = sel;
                    if (wreq[sel]) begin
                        in_axi_awready[sel] = 1'b1;
                        in_axi_wready[sel]  = 1'b1;
                        awaddr_d  = sel ? in_axi_awaddr[2*AW-1:AW] : in_axi_awaddr[AW-1:0];
                        wdata_d   = sel ? in_axi_wdata[2*DW-1:DW]  : in_axi_wdata[DW-1:0];
                        wstrb_d   = in_axi_wstrb[sel];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_ADDR;
                    end else begin
                        in_axi_arready[sel] = 1'b1;
                        araddr_d  = sel ? in_axi_araddr[2*AW-1:AW] : in_axi_araddr[AW-1:0];
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end

            S_WR_ADDR: begin
                awvalid_d = awvalid_q & ~out_axi_awready;
                wvalid_d  = wvalid_q  & ~out_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                in_axi_bvalid[grant_q] = out_axi_bvalid;
                out_axi_bready         = in_axi_bready[grant_q];
                if (out_axi_bvalid && in_axi_bready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end

            S_RD_ADDR: begin
                if (out_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_RESP;
                end
            end

            S_RD_RESP: begin
                in_axi_rvalid[grant_q] = out_axi_rvalid;
                out_axi_rready         = in_axi_rready[grant_q];
                if (out_axi_rvalid && in_axi_rready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge axi_clk) begin
        if (!axi_resetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
        end
    end

    assign out_axi_awaddr  = awaddr_q;
    assign out_axi_awvalid = awvalid_q;
    assign out_axi_wdata   = wdata_q;
    assign out_axi_wstrb   = wstrb_q;
    assign out_axi_wvalid  = wvalid_q;
    assign out_axi_araddr  = araddr_q;
    assign out_axi_arvalid = arvalid_q;

    // Response payloads are broadcast; only the granted master sees valid.
    assign in_axi_bresp = out_axi_bresp;
    assign in_axi_rresp = out_axi_rresp;
    assign in_axi_rdata = out_axi_rdata;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter with a small behavioural AXI-Lite memory slave (AW=10, DW=8).
// Expectations follow AXI_ARBITER_FIXED_PRIO_EN when it is defined.
module tb_axi_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [2*AW-1:0] in_awaddr, in_araddr;
    logic [2*DW-1:0] in_wdata;
    logic [1:0]      in_wstrb, in_awvalid, in_wvalid, in_arvalid, in_bready, in_rready;
    logic [1:0]      in_awready, in_wready, in_arready, in_bvalid, in_rvalid;
    logic [1:0]      in_bresp, in_rresp;
    logic [DW-1:0]   in_rdata;

    logic [AW-1:0]   out_awaddr, out_araddr;
    logic [DW-1:0]   out_wdata, out_rdata;
    logic            out_wstrb, out_awvalid, out_wvalid, out_arvalid, out_bready, out_rready;
    logic            out_awready, out_wready, out_arready, out_bvalid, out_rvalid;
    logic [1:0]      out_bresp, out_rresp;

    axi_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .axi_clk(clk), .axi_resetn(rstn),
        .in_axi_awaddr(in_awaddr), .in_axi_awvalid(in_awvalid), .in_axi_awready(in_awready),
        .in_axi_wdata(in_wdata), .in_axi_wstrb(in_wstrb), .in_axi_wvalid(in_wvalid),
        .in_axi_wready(in_wready), .in_axi_bresp(in_bresp), .in_axi_bvalid(in_bvalid),
        .in_axi_bready(in_bready), .in_axi_araddr(in_araddr), .in_axi_arvalid(in_arvalid),
        .in_axi_arready(in_arready), .in_axi_rdata(in_rdata), .in_axi_rresp(in_rresp),
        .in_axi_rvalid(in_rvalid), .in_axi_rready(in_rready),
        .out_axi_awaddr(out_awaddr), .out_axi_awvalid(out_awvalid), .out_axi_awready(out_awready),
        .out_axi_wdata(out_wdata), .out_axi_wstrb(out_wstrb), .out_axi_wvalid(out_wvalid),
        .out_axi_wready(out_wready), .out_axi_bresp(out_bresp), .out_axi_bvalid(out_bvalid),
        .out_axi_bready(out_bready), .out_axi_araddr(out_araddr), .out_axi_arvalid(out_arvalid),
        .out_axi_arready(out_arready), .out_axi_rdata(out_rdata), .out_axi_rresp(out_rresp),
        .out_axi_rvalid(out_rvalid), .out_axi_rready(out_rready)
    );

    // Behavioural memory slave; s_aw_en lets the bench stall the AW channel on its own.
    logic [DW-1:0] mem [1024];
    logic          s_aw_en;
    logic          s_aw_got, s_w_got, s_bvalid, s_rvalid, s_wstrb;
    logic [AW-1:0] s_awaddr;
    logic [DW-1:0] s_wdata, s_rdata;

    assign out_awready = s_aw_en & ~s_aw_got & ~s_bvalid;
    assign out_wready  = ~s_w_got & ~s_bvalid;
    assign out_arready = ~s_rvalid;
    assign out_bvalid  = s_bvalid;
    assign out_rvalid  = s_rvalid;
    assign out_rdata   = s_rdata;
    assign out_bresp   = 2'b00;
    assign out_rresp   = 2'b00;

    always @(posedge clk) begin
        if (!rstn) begin
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
        end else begin
            if (out_awvalid && out_awready) begin
                s_aw_got <= 1'b1;
                s_awaddr <= out_awaddr;
            end
            if (out_wvalid && out_wready) begin
                s_w_got <= 1'b1;
                s_wdata <= out_wdata;
                s_wstrb <= out_wstrb;
            end
            if (s_aw_got && s_w_got) begin
                if (s_wstrb) mem[s_awaddr] <= s_wdata;
                s_bvalid <= 1'b1;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end
            if (s_bvalid && out_bready) s_bvalid <= 1'b0;
            if (out_arvalid && out_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[out_araddr];
            end
            if (s_rvalid && out_rready) s_rvalid <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive point is 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        cyc();
        in_awaddr[m*AW +: AW] = a;
        in_wdata[m*DW +: DW]  = d;
        in_wstrb[m]   = 1'b1;
        in_awvalid[m] = 1'b1;
        in_wvalid[m]  = 1'b1;
        #1;
        n = 0;
        while (!(in_awready[m] && in_wready[m]) && n < 50) begin cyc(); #1; n++; end
        check("wr_accept_in_time", 32'(n < 50), 1);
        cyc();
        in_awvalid[m] = 1'b0;
        in_wvalid[m]  = 1'b0;
        #1;
        n = 0;
        while (!in_bvalid[m] && n < 50) begin cyc(); #1; n++; end
        check("wr_bvalid_in_time", 32'(n < 50), 1);
        check("wr_bresp", 32'(in_bresp), 0);
        check("wr_bvalid_other", 32'(in_bvalid[1-m]), 0);
        cyc();
    endtask

    task automatic do_read(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        cyc();
        in_araddr[m*AW +: AW] = a;
        in_arvalid[m] = 1'b1;
        #1;
        n = 0;
        while (!in_arready[m] && n < 50) begin cyc(); #1; n++; end
        check("rd_accept_in_time", 32'(n < 50), 1);
        cyc();
        in_arvalid[m] = 1'b0;
        #1;
        n = 0;
        while (!in_rvalid[m] && n < 50) begin cyc(); #1; n++; end
        check("rd_rvalid_in_time", 32'(n < 50), 1);
        check("rd_rdata", 32'(in_rdata), 32'(d));
        check("rd_rresp", 32'(in_rresp), 0);
        check("rd_rvalid_other", 32'(in_rvalid[1-m]), 0);
        cyc();
    endtask

    logic [AW-1:0] rd_addr [2][4];
    logic [DW-1:0] rd_data [2][4];
    int            exp_order [8];
    int            idx [2];

    initial begin
        int n;
        int win;

        rstn       = 1'b0;
        s_aw_en    = 1'b1;
        in_awaddr  = '0;
        in_araddr  = '0;
        in_wdata   = '0;
        in_wstrb   = '0;
        in_awvalid = '0;
        in_wvalid  = '0;
        in_arvalid = '0;
        in_bready  = 2'b11;
        in_rready  = 2'b11;

        rd_addr[0][0] = 10'h0B0; rd_data[0][0] = 8'h10;
        rd_addr[0][1] = 10'h0C0; rd_data[0][1] = 8'h20;
        rd_addr[0][2] = 10'h0D0; rd_data[0][2] = 8'h30;
        rd_addr[0][3] = 10'h0C1; rd_data[0][3] = 8'h21;
        rd_addr[1][0] = 10'h0C1; rd_data[1][0] = 8'h21;
        rd_addr[1][1] = 10'h0D0; rd_data[1][1] = 8'h30;
        rd_addr[1][2] = 10'h0C0; rd_data[1][2] = 8'h20;
        rd_addr[1][3] = 10'h0B0; rd_data[1][3] = 8'h10;
        for (int i = 0; i < 8; i++) begin
`ifdef AXI_ARBITER_FIXED_PRIO_EN
            exp_order[i] = (i < 4) ? 0 : 1;
`else
            exp_order[i] = i % 2;
`endif
        end

        // Reset state
        repeat (3) cyc();
        rstn = 1'b1;
        #1;
        check("rst_out_awvalid", 32'(out_awvalid), 0);
        check("rst_out_wvalid", 32'(out_wvalid), 0);
        check("rst_out_arvalid", 32'(out_arvalid), 0);
        check("rst_out_bready", 32'(out_bready), 0);
        check("rst_in_bvalid", 32'(in_bvalid), 0);
        check("rst_in_awready", 32'(in_awready), 0);
        check("rst_out_awaddr", 32'(out_awaddr), 0);

        // 1. Lone m0 write, cycle by cycle, then read back
        cyc();
        in_awaddr[AW-1:0] = 10'h0B0;
        in_wdata[DW-1:0]  = 8'h10;
        in_wstrb[0]   = 1'b1;
        in_awvalid[0] = 1'b1;
        in_wvalid[0]  = 1'b1;
        #1;
        check("t1_awready", 32'(in_awready), 32'b01);
        check("t1_wready", 32'(in_wready), 32'b01);
        check("t1_arready", 32'(in_arready), 0);
        check("t1_out_awvalid_pre", 32'(out_awvalid), 0);
        cyc();
        in_awvalid[0] = 1'b0;
        in_wvalid[0]  = 1'b0;
        #1;
        check("t1_out_awvalid", 32'(out_awvalid), 1);
        check("t1_out_wvalid", 32'(out_wvalid), 1);
        check("t1_out_awaddr", 32'(out_awaddr), 32'h0B0);
        check("t1_out_wdata", 32'(out_wdata), 32'h10);
        cyc(); #1;
        check("t1_awvalid_done", 32'(out_awvalid), 0);
        check("t1_wvalid_done", 32'(out_wvalid), 0);
        check("t1_bvalid_early", 32'(in_bvalid), 0);
        cyc(); #1;
        check("t1_bvalid", 32'(in_bvalid), 32'b01);
        check("t1_bresp", 32'(in_bresp), 0);
        cyc(); #1;
        check("t1_bvalid_clear", 32'(in_bvalid), 0);
        do_read(0, 10'h0B0, 8'h10);

        // 2. Simultaneous writes, fresh reset so m0 holds priority
        cyc();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
        in_awaddr = {10'h0C1, 10'h0C0};
        in_wdata  = {8'h21, 8'h20};
        in_wstrb  = 2'b11;
        in_awvalid = 2'b11;
        in_wvalid  = 2'b11;
        #1;
        check("t2_awready_m0", 32'(in_awready), 32'b01);
        check("t2_wready_m0", 32'(in_wready), 32'b01);
        cyc();
        in_awvalid[0] = 1'b0;
        in_wvalid[0]  = 1'b0;
        #1;
        check("t2_busy_awready", 32'(in_awready), 0);
        check("t2_out_awaddr_m0", 32'(out_awaddr), 32'h0C0);
        n = 0;
        while (!in_bvalid[0] && n < 50) begin cyc(); #1; n++; end
        check("t2_bvalid_m0", 32'(in_bvalid), 32'b01);
        cyc(); #1;
        check("t2_awready_m1", 32'(in_awready), 32'b10);
        check("t2_wready_m1", 32'(in_wready), 32'b10);
        cyc();
        in_awvalid[1] = 1'b0;
        in_wvalid[1]  = 1'b0;
        #1;
        check("t2_out_awaddr_m1", 32'(out_awaddr), 32'h0C1);
        check("t2_out_wdata_m1", 32'(out_wdata), 32'h21);
        n = 0;
        while (!in_bvalid[1] && n < 50) begin cyc(); #1; n++; end
        check("t2_bvalid_m1", 32'(in_bvalid), 32'b10);
        cyc();
        do_read(0, 10'h0C0, 8'h20);
        do_read(1, 10'h0C1, 8'h21);

        // 3. m0 holds bready low; m1 read stalls until the response completes
        cyc();
        in_bready[0] = 1'b0;
        in_awaddr[AW-1:0] = 10'h0D0;
        in_wdata[DW-1:0]  = 8'h30;
        in_awvalid[0] = 1'b1;
        in_wvalid[0]  = 1'b1;
        in_araddr[2*AW-1:AW] = 10'h0C1;
        in_arvalid[1] = 1'b1;
        #1;
        check("t3_awready_m0", 32'(in_awready), 32'b01);
        check("t3_arready_m1_idle", 32'(in_arready), 0);
        cyc();
        in_awvalid[0] = 1'b0;
        in_wvalid[0]  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            check("t3_m1_stalled", 32'(in_arready), 0);
        end
        check("t3_bvalid_held", 32'(in_bvalid), 32'b01);
        check("t3_out_bready_low", 32'(out_bready), 0);
        cyc();
        in_bready[0] = 1'b1;
        #1;
        check("t3_out_bready_high", 32'(out_bready), 1);
        cyc(); #1;
        check("t3_arready_m1", 32'(in_arready), 32'b10);
        check("t3_bvalid_clear", 32'(in_bvalid), 0);
        cyc();
        in_arvalid[1] = 1'b0;
        #1;
        n = 0;
        while (!in_rvalid[1] && n < 50) begin cyc(); #1; n++; end
        check("t3_rvalid_m1", 32'(in_rvalid), 32'b10);
        check("t3_rdata_m1", 32'(in_rdata), 32'h21);
        cyc();

        // 4. Both masters stream four reads each
        cyc();
        idx[0] = 0;
        idx[1] = 0;
        in_araddr  = {rd_addr[1][0], rd_addr[0][0]};
        in_arvalid = 2'b11;
        #1;
        for (int g = 0; g < 8; g++) begin
            n = 0;
            while (in_arready == 2'b00 && n < 50) begin cyc(); #1; n++; end
            check("t4_no_idle_gap", 32'(n), 0);
            check("t4_onehot", 32'($countones(in_arready)), 1);
            win = in_arready[1] ? 1 : 0;
            check("t4_grant_order", 32'(win), 32'(exp_order[g]));
            cyc();
            idx[win]++;
            if (idx[win] == 4) in_arvalid[win] = 1'b0;
            else in_araddr[win*AW +: AW] = rd_addr[win][idx[win]];
            #1;
            n = 0;
            while (!in_rvalid[win] && n < 50) begin cyc(); #1; n++; end
            check("t4_rdata", 32'(in_rdata), 32'(rd_data[win][idx[win]-1]));
            cyc(); #1;
        end

        // 5. Write beats read within one master
        cyc();
        in_awaddr[AW-1:0] = 10'h0E0;
        in_wdata[DW-1:0]  = 8'h40;
        in_araddr[AW-1:0] = 10'h0E0;
        in_awvalid[0] = 1'b1;
        in_wvalid[0]  = 1'b1;
        in_arvalid[0] = 1'b1;
        #1;
        check("t5_awready", 32'(in_awready), 32'b01);
        check("t5_arready_blocked", 32'(in_arready), 0);
        cyc();
        in_awvalid[0] = 1'b0;
        in_wvalid[0]  = 1'b0;
        #1;
        n = 0;
        while (!in_bvalid[0] && n < 50) begin cyc(); #1; n++; end
        check("t5_bvalid", 32'(in_bvalid), 32'b01);
        cyc(); #1;
        check("t5_arready_after", 32'(in_arready), 32'b01);
        cyc();
        in_arvalid[0] = 1'b0;
        #1;
        n = 0;
        while (!in_rvalid[0] && n < 50) begin cyc(); #1; n++; end
        check("t5_rdata", 32'(in_rdata), 32'h40);
        cyc();

        // 6. Reset while stuck in WR_ADDR (AW stalled, W already accepted)
        s_aw_en = 1'b0;
        cyc();
        in_awaddr[AW-1:0] = 10'h0F0;
        in_wdata[DW-1:0]  = 8'h55;
        in_awvalid[0] = 1'b1;
        in_wvalid[0]  = 1'b1;
        #1;
        check("t6_awready", 32'(in_awready), 32'b01);
        cyc();
        in_awvalid[0] = 1'b0;
        in_wvalid[0]  = 1'b0;
        #1;
        check("t6_both_valid", 32'({out_awvalid, out_wvalid}), 32'b11);
        cyc(); #1;
        check("t6_w_only_cleared", 32'({out_awvalid, out_wvalid}), 32'b10);
        cyc(); #1;
        check("t6_aw_still_held", 32'(out_awvalid), 1);
        cyc();
        rstn = 1'b0;
        in_araddr[2*AW-1:AW] = 10'h0B0;
        in_arvalid[1] = 1'b1;
        cyc(); #1;
        check("t6_rst_out_valids", 32'({out_awvalid, out_wvalid, out_arvalid}), 0);
        check("t6_rst_in_readys", 32'({in_awready, in_wready, in_arready}), 0);
        check("t6_rst_in_valids", 32'({in_bvalid, in_rvalid}), 0);
        check("t6_rst_awaddr", 32'(out_awaddr), 0);
        cyc();
        rstn = 1'b1;
        in_arvalid[1] = 1'b0;
        s_aw_en = 1'b1;
        do_write(0, 10'h0F0, 8'h66);
        do_read(0, 10'h0F0, 8'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
